flash_blk_fetch: RTL and testbench

FLASH_BLK_FETCH -- requirements
Module: flash_blk_fetch

---
 rtl/flash_blk_fetch.sv | 182 ++++++++++++++++++
 tb/tb_flash_blk_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_blk_fetch.sv
// ============================================================================
// Module   : flash_blk_fetch
// Purpose  : Fetches nblk 16-byte blocks from a byte-wide flash reader and
//            presents each assembled block (big-endian) on a valid/ready port.
// Options  : FLASH_FETCH_TIMEOUT_EN - when defined, a byte request that waits
//            TIMEOUT_CYC cycles without mem_ready_i aborts the fetch (err_o=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_blk_fetch #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [23:0]  base_addr_i,
    input  logic [7:0]   nblk_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         mem_valid_o,
    input  logic         mem_ready_i,
    output logic [23:0]  mem_addr_o,
    input  logic [7:0]   mem_rdata_i,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    output logic [127:0] blk_data_o,
    output logic [7:0]   blk_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // A zero timeout would make every request abort before it could complete.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("flash_blk_fetch: TIMEOUT_CYC must be at least 1");
    end

    state_t         state_q, state_d;
    logic [23:0]    base_q, base_d;
    logic [7:0]     nblk_q, nblk_d;
    logic [7:0]     blk_q, blk_d;
    logic [3:0]     byte_q, byte_d;
    logic [127:0]   data_q, data_d;
    logic           done_q, done_d;
    logic           w_timeout;

`ifdef FLASH_FETCH_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] tmo_q, tmo_d;
    logic               err_q, err_d;

    // Count cycles the current byte request has been waiting; restart per byte.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_REQ && !mem_ready_i) begin
            tmo_d = tmo_q + c_cnt_w'(1);
        end
    end

    assign w_timeout = (state_q == S_REQ) && !mem_ready_i && (tmo_q == c_cnt_last);

    // Timeout counter and error flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_d = w_timeout;
    assign err_o = err_q;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // Next-state logic: request sequencing, byte assembly and block hand-off.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        nblk_d  = nblk_q;
        blk_d   = blk_q;
        byte_d  = byte_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (nblk_i != 8'd0) begin
                        base_d  = base_addr_i;
                        nblk_d  = nblk_i;
                        blk_d   = 8'd0;
                        byte_d  = 4'd0;
                        data_d  = '0;
                        state_d = S_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready_i) begin
                    // Byte k lands in the k-th most significant byte lane.
                    for (int k = 0; k < 16; k++) begin
                        if (byte_q == k[3:0]) begin
                            data_d[127-8*k -: 8] = mem_rdata_i;
                        end
                    end
                    state_d = S_GAP;
                end else if (w_timeout) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (byte_q == 4'hF) begin
                    byte_d  = 4'd0;
                    state_d = S_OUT;
                end else begin
                    byte_d  = byte_q + 4'd1;
                    state_d = S_REQ;
                end
            end
            S_OUT: begin
                if (blk_ready_i) begin
                    if (blk_q == nblk_q - 8'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        blk_d   = blk_q + 8'd1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            nblk_q  <= '0;
            blk_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            nblk_q  <= nblk_d;
            blk_q   <= blk_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Address wraps naturally in 24 bits; it is zero after reset since all terms are.
    assign mem_addr_o  = base_q + {12'd0, blk_q, 4'd0} + {20'd0, byte_q};
    assign mem_valid_o = (state_q == S_REQ);
    assign blk_valid_o = (state_q == S_OUT);
    assign blk_data_o  = data_q;
    assign blk_idx_o   = blk_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_blk_fetch.sv
// ============================================================================
// Module   : tb_flash_blk_fetch
// Purpose  : Self-checking bench for flash_blk_fetch. A flash image model
//            (byte = address low byte XOR salt) supplies read data; expected
//            addresses and blocks are derived from base/block/byte arithmetic.
// Options  : FLASH_FETCH_TIMEOUT_EN - selects the timeout expectation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`define CHK(tag, obs, exp) chk(tag, 128'(obs), 128'(exp))

module tb_flash_blk_fetch;

    localparam int c_tcyc = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [23:0]  base_addr_i;
    logic [7:0]   nblk_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic         mem_valid_o;
    logic         mem_ready_i;
    logic [23:0]  mem_addr_o;
    logic [7:0]   mem_rdata_i;
    logic         blk_valid_o;
    logic         blk_ready_i;
    logic [127:0] blk_data_o;
    logic [7:0]   blk_idx_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flash_blk_fetch #(.TIMEOUT_CYC(c_tcyc)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .nblk_i      (nblk_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_data_o  (blk_data_o),
        .blk_idx_o   (blk_idx_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        n_chk++;
        if ((mem_valid_o & blk_valid_o) !== 1'b0) begin
            n_err++;
            $error("FAIL mon_excl: observed=%0b expected=0", mem_valid_o & blk_valid_o);
        end
        n_chk++;
        if ((done_o & busy_o) !== 1'b0) begin
            n_err++;
            $error("FAIL mon_done_idle: observed=%0b expected=0", done_o & busy_o);
        end
        n_chk++;
        if ((err_o & ~done_o) !== 1'b0) begin
            n_err++;
            $error("FAIL mon_err_qual: observed=%0b expected=0", err_o & ~done_o);
        end
    end

    function automatic logic [7:0] flash_byte(input logic [23:0] a, input logic [7:0] salt);
        return a[7:0] ^ salt;
    endfunction

    // Block b as the flash image holds it, first byte most significant.
    function automatic logic [127:0] exp_block(input logic [23:0] base, input int b, input logic [7:0] salt);
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) begin
            r = {r[119:0], flash_byte(base + 24'(16 * b + k), salt)};
        end
        return r;
    endfunction

    task automatic check_reset_vals(input string tag);
        `CHK({tag, "_mem_valid"}, mem_valid_o, 0);
        `CHK({tag, "_mem_addr"},  mem_addr_o,  0);
        `CHK({tag, "_blk_valid"}, blk_valid_o, 0);
        `CHK({tag, "_blk_data"},  blk_data_o,  0);
        `CHK({tag, "_blk_idx"},   blk_idx_o,   0);
        `CHK({tag, "_busy"},      busy_o,      0);
        `CHK({tag, "_done"},      done_o,      0);
        `CHK({tag, "_err"},       err_o,       0);
    endtask

    // Drive one fetch end to end, acting as flash reader and block sink.
    task automatic run_fetch(input logic [23:0] base, input int nblk,
                             input int lat_min, input int lat_max,
                             input int stall_min, input int stall_max,
                             input logic [7:0] salt,
                             input int abort_blk, input int abort_k,
                             input bit poke_start);
        logic [23:0] ea;
        int lat;
        int stall;
        start_i     = 1'b1;
        base_addr_i = base;
        nblk_i      = 8'(nblk);
        step();
        start_i     = 1'b0;
        base_addr_i = 24'($urandom);
        nblk_i      = 8'($urandom);
        if (nblk == 0) begin
            `CHK("zero_done", done_o, 1);
            `CHK("zero_err", err_o, 0);
            `CHK("zero_mem_valid", mem_valid_o, 0);
            `CHK("zero_busy", busy_o, 0);
            step();
            `CHK("zero_done_end", done_o, 0);
            `CHK("zero_mem_valid_end", mem_valid_o, 0);
            return;
        end
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 16; k++) begin
                ea = base + 24'(16 * b + k);
                if (b == abort_blk && k == abort_k) begin
                    `CHK("abort_mem_valid", mem_valid_o, 1);
                    rst_i = 1'b1;
                    step();
                    rst_i = 1'b0;
                    check_reset_vals("abort");
                    for (int i = 0; i < 3; i++) begin
                        step();
                        `CHK("abort_no_done", done_o, 0);
                        `CHK("abort_idle", busy_o, 0);
                    end
                    return;
                end
                lat = $urandom_range(lat_max, lat_min);
                for (int w = 0; w <= lat; w++) begin
                    `CHK("req_mem_valid", mem_valid_o, 1);
                    `CHK("req_addr", mem_addr_o, ea);
                    `CHK("req_blk_valid", blk_valid_o, 0);
                    `CHK("req_busy", busy_o, 1);
                    mem_ready_i = (w == lat);
                    mem_rdata_i = (w == lat) ? flash_byte(ea, salt) : 8'($urandom);
                    start_i     = poke_start && ($urandom_range(1, 0) == 1);
                    step();
                end
                mem_ready_i = 1'($urandom);
                mem_rdata_i = 8'($urandom);
                start_i     = poke_start && ($urandom_range(1, 0) == 1);
                `CHK("gap_mem_valid", mem_valid_o, 0);
                `CHK("gap_blk_valid", blk_valid_o, 0);
                `CHK("gap_busy", busy_o, 1);
                step();
                mem_ready_i = 1'b0;
                start_i     = 1'b0;
            end
            stall = $urandom_range(stall_max, stall_min);
            for (int s = 0; s <= stall; s++) begin
                `CHK("out_blk_valid", blk_valid_o, 1);
                `CHK("out_mem_valid", mem_valid_o, 0);
                `CHK("out_data", blk_data_o, exp_block(base, b, salt));
                `CHK("out_idx", blk_idx_o, b);
                `CHK("out_done", done_o, 0);
                blk_ready_i = (s == stall);
                mem_ready_i = 1'($urandom);
                start_i     = poke_start && ($urandom_range(1, 0) == 1);
                step();
            end
            blk_ready_i = 1'b0;
            mem_ready_i = 1'b0;
            start_i     = 1'b0;
        end
        `CHK("end_done", done_o, 1);
        `CHK("end_err", err_o, 0);
        `CHK("end_busy", busy_o, 0);
        `CHK("end_blk_valid", blk_valid_o, 0);
        `CHK("end_mem_valid", mem_valid_o, 0);
        step();
        `CHK("end_done_pulse", done_o, 0);
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        nblk_i      = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        blk_ready_i = 1'b0;
        step();
        step();
        check_reset_vals("reset");
        rst_i = 1'b0;
        step();
        check_reset_vals("post_reset");

        // Single block at 0x100, ready three cycles after each request.
        run_fetch(24'h000100, 1, 3, 3, 0, 0, 8'h00, -1, 0, 1'b0);

        // Address wrap across the top of the 24-bit space with sink stalls.
        run_fetch(24'hFFFFF8, 2, 0, 2, 5, 5, 8'h3C, -1, 0, 1'b0);

        // Zero-block request, then a fetch with start_i poked while busy.
        run_fetch(24'($urandom), 0, 0, 0, 0, 0, 8'h00, -1, 0, 1'b0);
        run_fetch(24'h123450, 2, 1, 4, 0, 3, 8'hA5, -1, 0, 1'b1);

        // Reset during byte 7 of block 1, then a clean fetch.
        run_fetch(24'hABCDE0, 3, 0, 2, 0, 2, 8'h5A, 1, 7, 1'b0);
        run_fetch(24'h000040, 2, 0, 3, 0, 2, 8'h81, -1, 0, 1'b0);

        // Flash reader that never answers.
        start_i     = 1'b1;
        base_addr_i = 24'h00ABC0;
        nblk_i      = 8'd3;
        step();
        start_i = 1'b0;
`ifdef FLASH_FETCH_TIMEOUT_EN
        for (int i = 0; i < c_tcyc; i++) begin
            `CHK("tmo_mem_valid", mem_valid_o, 1);
            `CHK("tmo_addr", mem_addr_o, 24'h00ABC0);
            `CHK("tmo_done_early", done_o, 0);
            step();
        end
        `CHK("tmo_mem_valid_drop", mem_valid_o, 0);
        `CHK("tmo_done", done_o, 1);
        `CHK("tmo_err", err_o, 1);
        `CHK("tmo_busy", busy_o, 0);
        step();
        `CHK("tmo_done_pulse", done_o, 0);
        `CHK("tmo_err_pulse", err_o, 0);
`else
        for (int i = 0; i < 40; i++) begin
            `CHK("hold_mem_valid", mem_valid_o, 1);
            `CHK("hold_addr", mem_addr_o, 24'h00ABC0);
            `CHK("hold_err", err_o, 0);
            `CHK("hold_done", done_o, 0);
            step();
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_reset_vals("hold_reset");
`endif

        // Randomized fetches with random latencies, stalls and start pokes.
        for (int r = 0; r < 6; r++) begin
            run_fetch(24'($urandom), $urandom_range(3, 1), 0, 4, 0, 4,
                      8'($urandom), -1, 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Absolute run-time bound so a stuck sequence still ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`undef CHK

`default_nettype wire
